pkt_rr_arb: RTL and testbench
=============================

PKT_RR_ARB -- requirements
Module: pkt_rr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the TDATA width of every stream.
REQ-002 SHALL have parameter NUM_SRC, default 4, the number of source streams; the legal range is 1 to 16.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the width of each per-source packet counter.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic SHALL be rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have src_TDATA (input, NUM_SRC*DATA_WIDTH bits); source i SHALL occupy bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have src_TVALID (input), src_TLAST (input) and src_TREADY (output), each NUM_SRC bits, one bit per source.
REQ-008 SHALL have res_TDATA (output, DATA_WIDTH bits), res_TVALID (output, 1 bit), res_TREADY (input, 1 bit) and res_TLAST (output, 1 bit): the merged output stream.
REQ-009 SHALL have res_TID, output, max(1,clog2(NUM_SRC)) bits: the index of the source that owns the current output flit.
REQ-010 SHALL have busy, output, 1 bit: high while in the GRANT state.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and GRANT, with a registered grant index g and a registered last-served index lst.
REQ-012 In IDLE, when any src_TVALID bit is high, the FSM SHALL choose g as the first valid source scanning lst+1, lst+2, ... modulo NUM_SRC, and SHALL move to GRANT on the next edge.
REQ-013 In IDLE, every src_TREADY bit SHALL be 0.
REQ-014 In GRANT, src_TREADY[g] SHALL equal the output-buffer ready; all other src_TREADY bits SHALL be 0.
REQ-015 In GRANT, the grant SHALL be held across TVALID gaps and res_TREADY stalls until a flit with TLAST is accepted from source g.
REQ-016 On acceptance of a flit with TLAST, lst SHALL take the value g and the FSM SHALL return to IDLE, giving one idle input cycle between packets.
REQ-017 An accepted flit SHALL appear on res_* exactly 1 cycle after acceptance when the output is not stalled; res_TID SHALL travel with its flit.
REQ-018 The output buffer SHALL hold 2 entries, SHALL sustain 1 flit per cycle in GRANT, and SHALL never drop or duplicate a flit.
REQ-019 With NUM_SRC=1, the block SHALL degenerate to a packet-gated pass-through with res_TID=0.
REQ-020 A packet without TLAST SHALL hold the grant indefinitely; this is intended behaviour.

Reset
REQ-021 rst SHALL force: FSM=IDLE, g=0, lst=NUM_SRC-1 (so source 0 wins first), output buffer empty, res_TVALID=0, busy=0, all src_TREADY=0, counters=0.
REQ-022 rst asserted mid-packet SHALL discard the buffered flits and SHALL NOT synthesize a TLAST; upstream is responsible for resynchronising its framing.

Configuration
REQ-023 With macro PKT_RR_ARB_STATS_EN defined, the block SHALL add output pkt_cnt, NUM_SRC*CNT_WIDTH bits, where counter i increments on each TLAST accepted from source i and wraps from all-ones to 0.
REQ-024 With PKT_RR_ARB_STATS_EN undefined, the pkt_cnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 The FSM state encodings (IDLE=0, GRANT=1) and the TID width function SHALL reside in the shared package pkt_arb_pkg.
REQ-026 The 2-entry output buffer SHALL be the sub-module pkt_arb_skid, with ports clk, rst, idata, idata_vld, idata_rdy, odata, odata_vld and odata_rdy; the buffered data SHALL be {TDATA, TLAST, TID}.

Verification
REQ-027 After reset, with src1 and src3 both valid and res_TREADY=1 -> src1 packet first (res_TID=1), then src3 packet (res_TID=3).
REQ-028 With all 4 sources sending 3-flit packets continuously -> output TID order 0,1,2,3,0,1,... and no interleaving of flits within a packet.
REQ-029 res_TREADY low for 5 cycles mid-packet -> no flit lost or duplicated, grant unchanged, and src_TREADY[g]=0 once the buffer is full.
REQ-030 Granted source deasserts TVALID for 3 cycles mid-packet while src2 is valid -> grant held, and src2 is served only after the TLAST.
REQ-031 rst pulsed on the 2nd flit of a packet -> next cycle res_TVALID=0 and FSM=IDLE, and source 0 wins the next arbitration.
REQ-032 With PKT_RR_ARB_STATS_EN, 10 packets from src2 -> pkt_cnt[2]=10 and all other counters 0; with counter i preloaded to 0xFFFF, one more packet from source i -> counter i=0.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: FSM encoding and TID sizing.
package pkt_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int tid_width(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/pkt_arb_skid.sv
// Two-entry output buffer: a write is visible on odata the next cycle; 1 flit/cycle sustained.
// Backpressure: idata_rdy depends only on occupancy (low when both entries are full), never on odata_rdy.
module pkt_arb_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] idata,
  input  logic             idata_vld,
  output logic             idata_rdy,
  output logic [WIDTH-1:0] odata,
  output logic             odata_vld,
  input  logic             odata_rdy
);

  logic [WIDTH-1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  assign idata_rdy = (cnt != 2'd2);
  assign odata_vld = (cnt != 2'd0);
  assign odata     = mem[rptr];
  assign push      = idata_vld && idata_rdy;
  assign pop       = odata_vld && odata_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= idata;
  end

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-atomic round-robin merge of NUM_SRC streams; flits leave 1 cycle after acceptance via a 2-entry buffer.
// Only the granted source sees ready (low when the buffer is full); PKT_RR_ARB_STATS_EN adds per-source packet counters.
module pkt_rr_arb
  import pkt_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SRC    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_TDATA,
  input  logic [NUM_SRC-1:0]            src_TVALID,
  input  logic [NUM_SRC-1:0]            src_TLAST,
  output logic [NUM_SRC-1:0]            src_TREADY,
  output logic [DATA_WIDTH-1:0]         res_TDATA,
  output logic                          res_TVALID,
  input  logic                          res_TREADY,
  output logic                          res_TLAST,
  output logic [tid_width(NUM_SRC)-1:0] res_TID,
  output logic                          busy
`ifdef PKT_RR_ARB_STATS_EN
  ,
  output logic [NUM_SRC*CNT_WIDTH-1:0]  pkt_cnt
`endif
);

  localparam int TID_W = tid_width(NUM_SRC);
  localparam int BUF_W = DATA_WIDTH + 1 + TID_W;

  arb_state_t                    state;
  logic [TID_W-1:0]              g;
  logic [TID_W-1:0]              lst;
  logic [TID_W-1:0]              pick;
  logic [NUM_SRC*DATA_WIDTH-1:0] data_sh;
  logic [NUM_SRC-1:0]            vld_sh;
  logic [NUM_SRC-1:0]            last_sh;
  logic [NUM_SRC-1:0]            rot;
  logic [DATA_WIDTH-1:0]         cur_data;
  logic                          cur_vld;
  logic                          cur_last;
  logic                          buf_vld;
  logic                          buf_rdy;
  logic                          accept;
  logic [BUF_W-1:0]              buf_out;

  always_comb begin
    data_sh = src_TDATA >> (int'(g) * DATA_WIDTH);
    vld_sh  = src_TVALID >> g;
    last_sh = src_TLAST >> g;
  end

  assign cur_data = data_sh[DATA_WIDTH-1:0];
  assign cur_vld  = vld_sh[0];
  assign cur_last = last_sh[0];
  assign buf_vld  = (state == GRANT) && cur_vld;
  assign accept   = buf_vld && buf_rdy;

  // Scan lst+1 .. lst+NUM_SRC backwards so the nearest valid source is written last and wins.
  always_comb begin
    pick = g;
    rot  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      rot = src_TVALID >> ((int'(lst) + k) % NUM_SRC);
      if (rot[0]) pick = TID_W'((int'(lst) + k) % NUM_SRC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      g     <= '0;
      lst   <= TID_W'(NUM_SRC - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|src_TVALID) begin
            g     <= pick;
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (accept && cur_last) begin
            lst   <= g;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    src_TREADY = '0;
    if (state == GRANT) src_TREADY = NUM_SRC'(buf_rdy) << g;
  end

  pkt_arb_skid #(
    .WIDTH (BUF_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .idata     ({cur_data, cur_last, g}),
    .idata_vld (buf_vld),
    .idata_rdy (buf_rdy),
    .odata     (buf_out),
    .odata_vld (res_TVALID),
    .odata_rdy (res_TREADY)
  );

  assign {res_TDATA, res_TLAST, res_TID} = buf_out;

`ifdef PKT_RR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (accept && cur_last) begin
      pkt_cnt[int'(g)*CNT_WIDTH +: CNT_WIDTH] <=
        pkt_cnt[int'(g)*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Randomised and directed bench for pkt_rr_arb against a queue-based reference model.
module tb_pkt_rr_arb;

  localparam int DW = 64;
  localparam int NS = 4;
  localparam int CW = 16;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*DW-1:0] src_TDATA;
  logic [NS-1:0]   src_TVALID;
  logic [NS-1:0]   src_TLAST;
  logic [NS-1:0]   src_TREADY;
  logic [DW-1:0]   res_TDATA;
  logic            res_TVALID;
  logic            res_TREADY;
  logic            res_TLAST;
  logic [TW-1:0]   res_TID;
  logic            busy;
`ifdef PKT_RR_ARB_STATS_EN
  logic [NS*CW-1:0] pkt_cnt;
`endif

  pkt_rr_arb #(
    .DATA_WIDTH (DW),
    .NUM_SRC    (NS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_TDATA  (src_TDATA),
    .src_TVALID (src_TVALID),
    .src_TLAST  (src_TLAST),
    .src_TREADY (src_TREADY),
    .res_TDATA  (res_TDATA),
    .res_TVALID (res_TVALID),
    .res_TREADY (res_TREADY),
    .res_TLAST  (res_TLAST),
    .res_TID    (res_TID),
    .busy       (busy)
`ifdef PKT_RR_ARB_STATS_EN
    ,
    .pkt_cnt    (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // source-side stimulus state
  int pend[NS];
  int len[NS];
  int idx[NS];
  int seq[NS];
  int hold_off[NS];
  int fix_len;
  int gap_pct;
  int rdy_pct;
  int stall_cnt;
  int rst_cycles;

  // reference model: grant owner, last served, output buffer contents
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            tid;
  } flit_t;
  bit    m_grant;
  int    m_g;
  int    m_lst;
  flit_t mq[$];
  int    m_cnt[NS];
  int    out_tid[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_at(logic [NS-1:0] v, int k);
    logic [NS-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic logic [DW-1:0] lane(int k);
    logic [NS*DW-1:0] t;
    t = src_TDATA >> (k * DW);
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mk(int s);
    return {8'(s), 24'(seq[s]), 16'(idx[s]), 16'(16'hA5C3 ^ 16'(s * 7 + idx[s]))};
  endfunction

  task automatic model_reset();
    m_grant = 1'b0;
    m_g     = 0;
    m_lst   = NS - 1;
    mq.delete();
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
  endtask

  task automatic load(int s);
    if (len[s] == 0 && pend[s] > 0) begin
      pend[s]--;
      len[s] = (fix_len > 0) ? fix_len : int'($urandom_range(1, 4));
      idx[s] = 0;
    end
  endtask

  task automatic drive();
    rst = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    res_TREADY = (stall_cnt == 0) && (int'($urandom_range(99)) < rdy_pct);
    if (stall_cnt > 0) stall_cnt--;
    for (int i = 0; i < NS; i++) begin
      load(i);
      src_TVALID[i] = (len[i] > 0) && (hold_off[i] == 0) && (int'($urandom_range(99)) >= gap_pct);
      src_TLAST[i]  = (len[i] > 0) && (idx[i] == len[i] - 1);
      src_TDATA[i*DW +: DW] = (len[i] > 0) ? mk(i) : '0;
      if (hold_off[i] > 0) hold_off[i]--;
    end
  endtask

  // Compare this cycle's outputs with the model, then advance model and sources past the coming edge.
  task automatic step();
    logic [NS-1:0] exp_rdy;
    bit            acc;
    bit            found;
    exp_rdy = '0;
    if (m_grant && mq.size() < 2) exp_rdy = NS'(1) << m_g;
    chk("busy", busy, m_grant);
    chk("src_TREADY", src_TREADY, exp_rdy);
    chk("res_TVALID", res_TVALID, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("res_TDATA", res_TDATA, mq[0].d);
      chk("res_TLAST", res_TLAST, mq[0].l);
      chk("res_TID", res_TID, mq[0].tid);
    end
`ifdef PKT_RR_ARB_STATS_EN
    for (int i = 0; i < NS; i++) chk("pkt_cnt", pkt_cnt[i*CW +: CW], m_cnt[i]);
`endif
    if (rst) begin
      model_reset();
      for (int i = 0; i < NS; i++) begin
        if (len[i] > 0) begin
          len[i] = 0;
          idx[i] = 0;
          seq[i]++;
        end
      end
    end else begin
      acc = m_grant && bit_at(src_TVALID, m_g) && (mq.size() < 2);
      if (mq.size() != 0 && res_TREADY) begin
        out_tid.push_back(mq[0].tid);
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back('{d: lane(m_g), l: bit_at(src_TLAST, m_g), tid: m_g});
        if (bit_at(src_TLAST, m_g)) begin
          m_cnt[m_g] = (m_cnt[m_g] + 1) % (1 << CW);
          m_lst      = m_g;
          m_grant    = 1'b0;
        end
      end else if (!m_grant && (|src_TVALID)) begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          if (!found && bit_at(src_TVALID, (m_lst + k) % NS)) begin
            m_g   = (m_lst + k) % NS;
            found = 1'b1;
          end
        end
        m_grant = 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
        if (src_TVALID[i] && src_TREADY[i] && len[i] > 0) begin
          if (idx[i] == len[i] - 1) begin
            len[i] = 0;
            idx[i] = 0;
            seq[i]++;
          end else begin
            idx[i]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    step();
  endtask

  function automatic bit all_done();
    bit d;
    d = !m_grant && (mq.size() == 0);
    for (int i = 0; i < NS; i++) if (len[i] != 0 || pend[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL %s drain timeout: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_idx(string name, int s, int v);
    int n;
    n = 0;
    while (idx[s] < v && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (idx[s] < v) begin
      errors++;
      $display("FAIL %s wait timeout: flit index %0d, required %0d", name, idx[s], v);
    end
  endtask

  task automatic chk_order(string name, int exp[$]);
    chk({name, "_count"}, out_tid.size(), exp.size());
    foreach (exp[k]) chk(name, (k < out_tid.size()) ? out_tid[k] : -1, exp[k]);
  endtask

  initial begin
    int exp_q[$];
    rst        = 1'b1;
    res_TREADY = 1'b0;
    src_TDATA  = '0;
    src_TVALID = '0;
    src_TLAST  = '0;
    for (int i = 0; i < NS; i++) begin
      pend[i] = 0; len[i] = 0; idx[i] = 0; seq[i] = 0; hold_off[i] = 0;
    end
    fix_len = 2; gap_pct = 0; rdy_pct = 100; stall_cnt = 0; rst_cycles = 3;
    model_reset();

    // reset state
    repeat (4) tick();
    chk("reset_busy", busy, 0);
    chk("reset_res_TVALID", res_TVALID, 0);
    chk("reset_src_TREADY", src_TREADY, 0);

    // src1 and src3 together after reset: 1 first
    out_tid.delete();
    pend[1] = 1; pend[3] = 1;
    drain("two_src", 100);
    chk_order("two_src_order", '{1, 1, 3, 3});

    // all four sources, back-to-back 3-flit packets
    out_tid.delete();
    fix_len = 3;
    for (int i = 0; i < NS; i++) pend[i] = 2;
    drain("all_src", 300);
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        repeat (3) exp_q.push_back(s);
    chk_order("all_src_order", exp_q);

    // output stall mid-packet
    out_tid.delete();
    fix_len = 8;
    pend[0] = 1;
    wait_idx("stall", 0, 2);
    stall_cnt = 5;
    repeat (4) tick();
    chk("stall_src_TREADY", src_TREADY, 0);
    chk("stall_busy", busy, 1);
    drain("stall", 100);
    chk_order("stall_order", '{0, 0, 0, 0, 0, 0, 0, 0});

    // granted source gaps while src2 waits
    out_tid.delete();
    fix_len = 4;
    pend[0] = 1;
    wait_idx("gap", 0, 1);
    hold_off[0] = 3;
    pend[2] = 1;
    drain("gap", 100);
    chk_order("gap_order", '{0, 0, 0, 0, 2, 2, 2, 2});

    // reset on the second flit of a packet
    pend[0] = 1;
    drain("pre_rst", 100);
    pend[2] = 1;
    wait_idx("mid_rst", 2, 1);
    rst_cycles = 1;
    tick();
    out_tid.delete();
    pend[0] = 1; pend[1] = 1;
    tick();
    chk("mid_rst_res_TVALID", res_TVALID, 0);
    chk("mid_rst_busy", busy, 0);
    drain("post_rst", 100);
    chk_order("post_rst_order", '{0, 0, 0, 0, 1, 1, 1, 1});

    // random traffic, gaps and backpressure
    fix_len = 0; gap_pct = 30; rdy_pct = 70;
    for (int i = 0; i < NS; i++) pend[i] = int'($urandom_range(5, 15));
    drain("random", 6000);

`ifdef PKT_RR_ARB_STATS_EN
    gap_pct = 0; rdy_pct = 100; fix_len = 2;
    rst_cycles = 1;
    repeat (2) tick();
    pend[2] = 10;
    drain("stats", 400);
    for (int i = 0; i < NS; i++) chk("stats_cnt", pkt_cnt[i*CW +: CW], (i == 2) ? 10 : 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
